sip_inv_round_engine: RTL and testbench



---
 rtl/sip_inv_if.sv | 34 +++
 rtl/sip_inv_round_engine.sv | 83 ++++++++
 tb/tb_sip_inv_round_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sip_inv_if.sv
// Valid/ready job bundle for the SipRound inverter.
// master = job producer / result consumer, slave = engine.
interface sip_inv_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_v0;
    logic [63:0]      in_v1;
    logic [63:0]      in_v2;
    logic [63:0]      in_v3;
    logic [CNT_W-1:0] in_count;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_v0;
    logic [63:0]      out_v1;
    logic [63:0]      out_v2;
    logic [63:0]      out_v3;
    logic             busy;

    modport master (
        output in_valid, in_v0, in_v1, in_v2, in_v3, in_count,
        output out_ready,
        input  in_ready, out_valid, busy,
        input  out_v0, out_v1, out_v2, out_v3
    );

    modport slave (
        input  in_valid, in_v0, in_v1, in_v2, in_v3, in_count,
        input  out_ready,
        output in_ready, out_valid, busy,
        output out_v0, out_v1, out_v2, out_v3
    );
endinterface

// File: rtl/sip_inv_round_engine.sv
// Iterative inverse SipRound: one inverse round per clock,
// looping the state registers through a single round instance.
module sip_inv_round_engine #(
    parameter int CNT_W = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    sip_inv_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       fsm;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      s0, s1, s2, s3;
    logic [63:0]      r0, r1, r2, r3;
    logic [63:0]      t3, u0, b2, t1, u2, a0;

    function automatic logic [63:0] rotr(logic [63:0] x, int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Undo the forward round half by half, last operation first.
    always_comb begin
        t3 = rotr(s3 ^ s0, 21);
        u0 = s0 - t3;
        b2 = rotr(s2, 32);
        t1 = rotr(s1 ^ b2, 17);
        u2 = b2 - t1;
        r3 = rotr(t3 ^ u2, 16);
        r2 = u2 - r3;
        a0 = rotr(u0, 32);
        r1 = rotr(t1 ^ a0, 13);
        r0 = a0 - r1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            cnt <= '0;
            s0  <= '0;
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        s0  <= bus.in_v0;
                        s1  <= bus.in_v1;
                        s2  <= bus.in_v2;
                        s3  <= bus.in_v3;
                        cnt <= bus.in_count;
                        fsm <= (bus.in_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    s0  <= r0;
                    s1  <= r1;
                    s2  <= r2;
                    s3  <= r3;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        fsm <= DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (fsm == IDLE);
    assign bus.out_valid = (fsm == DONE);
    assign bus.busy      = (fsm != IDLE);
    assign bus.out_v0    = s0;
    assign bus.out_v1    = s1;
    assign bus.out_v2    = s2;
    assign bus.out_v3    = s3;
endmodule

// File: tb/tb_sip_inv_round_engine.sv
// Bench for sip_inv_round_engine: vectors, corner sequences and
// random round trips against a forward SipRound model.
module tb_sip_inv_round_engine;
    typedef logic [3:0][63:0] st_t;

    typedef struct {
        st_t vin;
        int  n;
        st_t vexp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    sip_inv_if #(.CNT_W(4)) bus ();

    sip_inv_round_engine #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] rotl(logic [63:0] x, int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // Forward SipRound as written in the SipHash paper.
    function automatic st_t fwd(st_t s);
        logic [63:0] v0, v1, v2, v3;
        v0 = s[0]; v1 = s[1]; v2 = s[2]; v3 = s[3];
        v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
        v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
        v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
        v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
        return {v3, v2, v1, v0};
    endfunction

    function automatic st_t fwdn(st_t s, int n);
        st_t r = s;
        for (int i = 0; i < n; i++) r = fwd(r);
        return r;
    endfunction

    function automatic st_t mk(logic [63:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(string nm, st_t e);
        chk({nm, " v0"}, bus.out_v0, e[0]);
        chk({nm, " v1"}, bus.out_v1, e[1]);
        chk({nm, " v2"}, bus.out_v2, e[2]);
        chk({nm, " v3"}, bus.out_v3, e[3]);
    endtask

    task automatic offer(st_t s, int n);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("wait in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_v0 = s[0]; bus.in_v1 = s[1];
        bus.in_v2 = s[2]; bus.in_v3 = s[3];
        bus.in_count = n[3:0];
        @(posedge clk); #1;
    endtask

    // Accept a job, keep offering junk while busy, check latency/data.
    task automatic run_job(string nm, st_t s, int n, st_t e);
        int lat = 0;
        offer(s, n);
        bus.in_v0 = rnd64(); bus.in_v1 = rnd64();
        bus.in_v2 = rnd64(); bus.in_v3 = rnd64();
        bus.in_count = 4'hf;
        while (!bus.out_valid && lat < 40) begin
            chk({nm, " busy"}, bus.busy, 1);
            @(posedge clk); #1; lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(n));
        chk({nm, " in_ready in DONE"}, bus.in_ready, 0);
        chk_out(nm, e);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, " in_ready after"}, bus.in_ready, 1);
        chk({nm, " out_valid after"}, bus.out_valid, 0);
    endtask

    initial begin
        vec_t tbl[5];
        st_t  key, z, pt, s, e;
        int   n, w;

        key = mk(64'h7469686173716475, 64'h6b617f6d656e6665,
                 64'h6b7f62616d677361, 64'h7b6b696e727e6c7b);
        z   = '0;
        pt  = mk(64'h0123456789abcdef, 64'hfedcba9876543210,
                 64'h0f0f0f0f0f0f0f0f, 64'hf0f0f0f0f0f0f0f0);
        tbl[0] = '{vin: z,              n: 3,  vexp: z};
        tbl[1] = '{vin: pt,             n: 0,  vexp: pt};
        tbl[2] = '{vin: fwdn(key, 2),   n: 2,  vexp: key};
        tbl[3] = '{vin: fwdn(key, 4),   n: 4,  vexp: key};
        tbl[4] = '{vin: fwdn(key, 15),  n: 15, vexp: key};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_v0 = '0; bus.in_v1 = '0; bus.in_v2 = '0; bus.in_v3 = '0;
        bus.in_count = '0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk_out("reset", z);

        foreach (tbl[i])
            run_job($sformatf("vec%0d", i), tbl[i].vin, tbl[i].n, tbl[i].vexp);

        // Backpressure: hold DONE for 10 cycles
        offer(fwdn(key, 2), 2);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 40) begin
            @(posedge clk); #1; w++;
        end
        chk("bp latency", 64'(w), 64'd2);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp out_valid", bus.out_valid, 1);
            chk("bp in_ready", bus.in_ready, 0);
            chk_out("bp", key);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp release in_ready", bus.in_ready, 1);

        // Reset after 5 of 15 rounds
        offer(fwdn(key, 15), 15);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst busy", bus.busy, 0);
        chk_out("rst", z);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst in_ready", bus.in_ready, 1);
        run_job("post-rst", fwd(key), 1, key);

        for (int k = 0; k < 200; k++) begin
            s = mk(rnd64(), rnd64(), rnd64(), rnd64());
            n = int'($urandom_range(0, 15));
            e = fwdn(s, n);
            run_job($sformatf("rnd%0d n=%0d", k, n), e, n, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
